// File: rtl/rom_download_sequencer_if.sv
// Download-side and ROM-side signals of rom_download_sequencer.
// The master modport is the environment (hps_io plus the ROM sink); the slave is the sequencer.
interface rom_download_sequencer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [26:0]       ioctl_addr;
  logic [15:0]       ioctl_dout;
  logic              ioctl_wait;
  logic              rom_ready;
  logic [3:0]        rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              load_busy;
  logic              load_done;
  logic              load_err;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ready,
    input  ioctl_wait, rom_we, rom_addr, rom_data, load_busy, load_done, load_err
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ready,
    output ioctl_wait, rom_we, rom_addr, rom_data, load_busy, load_done, load_err
  );
endinterface

// File: rtl/rom_download_sequencer.sv
// Buffers 16-bit ioctl download words in a 2-entry FIFO and replays each as two byte writes
// (low byte first) into one of four ROM regions, with backpressure and load status.
module rom_download_sequencer #(
  parameter logic [7:0]  INDEX   = 8'd0,
  parameter int unsigned ADDR_W  = 16,
  parameter logic [26:0] R1_BASE = 27'h08000,
  parameter logic [26:0] R2_BASE = 27'h10000,
  parameter logic [26:0] R3_BASE = 27'h18000,
  parameter logic [26:0] ROM_END = 27'h20000
) (
  input logic                     clk_sys,
  input logic                     reset_n,
  rom_download_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  function automatic logic [3:0] region_we(input logic [26:0] a);
    if (a < R1_BASE)      return 4'b0001;
    else if (a < R2_BASE) return 4'b0010;
    else if (a < R3_BASE) return 4'b0100;
    else if (a < ROM_END) return 4'b1000;
    else                  return 4'b0000;
  endfunction

  function automatic logic [ADDR_W-1:0] region_off(input logic [26:0] a);
    logic [26:0] rel;
    if (a < R1_BASE)      rel = a;
    else if (a < R2_BASE) rel = a - R1_BASE;
    else if (a < R3_BASE) rel = a - R2_BASE;
    else                  rel = a - R3_BASE;
    return ADDR_W'(rel);
  endfunction

  state_e            state_q;
  logic [26:0]       fifo_addr_q [2];
  logic [15:0]       fifo_data_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic [3:0]        rom_we_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [7:0]        rom_data_q;
  logic              skip_q;  // presented byte is out of range; consumed without a strobe
  logic              wait_q, busy_q, done_q, err_q;

  logic              dl_match, push, push_ok, drop, byte_done, pop, busy_d;
  logic [1:0]        cnt_after_pop, count_d;
  logic [26:0]       head_addr, hi_addr;
  logic [15:0]       head_data;
  logic [3:0]        lo_we, hi_we;

  // Handshake decode and selection of the word the engine starts next.
  // The word being replayed stays in the FIFO until its high byte is consumed.
  always_comb begin
    dl_match      = bus.ioctl_download && (bus.ioctl_index == INDEX);
    push          = bus.ioctl_wr && dl_match;
    push_ok       = push && (count_q != 2'd2);
    drop          = push && (count_q == 2'd2);
    byte_done     = (state_q != StIdle) && (skip_q || bus.rom_ready);
    pop           = (state_q == StHi) && byte_done;
    cnt_after_pop = count_q - {1'b0, pop};
    count_d       = cnt_after_pop + {1'b0, push_ok};
    // Empty FIFO after the pop: bypass the incoming word so the low byte appears next cycle.
    head_addr     = bus.ioctl_addr;
    head_data     = bus.ioctl_dout;
    if (cnt_after_pop != 2'd0) begin
      head_addr = fifo_addr_q[rd_ptr_q ^ pop];
      head_data = fifo_data_q[rd_ptr_q ^ pop];
    end
    hi_addr       = fifo_addr_q[rd_ptr_q] | 27'd1;
    lo_we         = region_we(head_addr);
    hi_we         = region_we(hi_addr);
    busy_d        = busy_q ? (bus.ioctl_download || (count_d != 2'd0)) : dl_match;
  end

  // Word FIFO storage and pointers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      fifo_addr_q[0] <= '0;
      fifo_addr_q[1] <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      if (push_ok) begin
        fifo_addr_q[wr_ptr_q] <= bus.ioctl_addr;
        fifo_data_q[wr_ptr_q] <= bus.ioctl_dout;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Byte engine with registered ROM outputs; outputs only change when a byte completes.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rom_we_q   <= 4'd0;
      rom_addr_q <= '0;
      rom_data_q <= 8'd0;
      skip_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHi: begin
          if ((state_q == StIdle) || byte_done) begin
            if (count_d != 2'd0) begin
              state_q    <= StLo;
              rom_we_q   <= lo_we;
              rom_addr_q <= region_off(head_addr);
              rom_data_q <= head_data[7:0];
              skip_q     <= (lo_we == 4'd0);
            end else begin
              state_q  <= StIdle;
              rom_we_q <= 4'd0;
              skip_q   <= 1'b0;
            end
          end
        end
        StLo: begin
          if (byte_done) begin
            state_q    <= StHi;
            rom_we_q   <= hi_we;
            rom_addr_q <= region_off(hi_addr);
            rom_data_q <= fifo_data_q[rd_ptr_q][15:8];
            skip_q     <= (hi_we == 4'd0);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Backpressure and load status.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= (count_d != 2'd0);
      busy_q <= busy_d;
      done_q <= busy_q && !busy_d;
      if (drop || (byte_done && skip_q)) begin
        err_q <= 1'b1;
      end else if (busy_d && !busy_q) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.rom_we     = rom_we_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_data   = rom_data_q;
  assign bus.load_busy  = busy_q;
  assign bus.load_done  = done_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_rom_download_sequencer.sv
// Scoreboard bench for rom_download_sequencer: the driver queues hand-computed byte writes,
// a monitor compares every accepted ROM write against the queue.
module tb_rom_download_sequencer;

  logic clk_sys = 1'b0;
  logic reset_n;

  rom_download_sequencer_if #(.ADDR_W(16)) bus ();

  rom_download_sequencer #(
    .INDEX  (8'd0),
    .ADDR_W (16)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [27:0] sb_q [$];  // {we, offset, byte}
  logic [27:0] sb_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every byte the sink accepts must match the head of the scoreboard.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      sb_q.delete();
    end else if ((bus.rom_we != 4'd0) && bus.rom_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {4'd0, bus.rom_we, bus.rom_addr, bus.rom_data}, 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check("sb_byte", {4'd0, bus.rom_we, bus.rom_addr, bus.rom_data}, {4'd0, sb_exp});
      end
    end
  end

  always @(negedge clk_sys) begin
    if (reset_n && bus.load_done) done_cnt++;
  end

  // Issue one ioctl word; optionally honour ioctl_wait first. Called just after a rising edge.
  task automatic send(input logic [26:0] a, input logic [15:0] d, input logic [3:0] we,
                      input logic [15:0] off, input bit gate);
    if (gate) begin
      for (int i = 0; i < 60 && bus.ioctl_wait; i++) begin
        @(posedge clk_sys);
        #1;
      end
      check("wait_released", {31'd0, bus.ioctl_wait}, 32'd0);
    end
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (we != 4'd0) begin
      sb_q.push_back({we, off, d[7:0]});
      sb_q.push_back({we, off + 16'd1, d[15:8]});
    end
    @(posedge clk_sys);
    #1;
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic end_load(input string tag, input logic exp_err);
    int d0;
    d0 = done_cnt;
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 60 && bus.load_busy; i++) @(negedge clk_sys);
    repeat (3) @(negedge clk_sys);
    check({tag, "_busy_low"}, {31'd0, bus.load_busy}, 32'd0);
    check({tag, "_done_once"}, done_cnt - d0, 32'd1);
    check({tag, "_err"}, {31'd0, bus.load_err}, {31'd0, exp_err});
    check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 27'd0;
    bus.ioctl_dout     = 16'd0;
    bus.rom_ready      = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_outputs", {bus.ioctl_wait, bus.rom_we, bus.rom_addr, bus.rom_data,
                          bus.load_busy, bus.load_done, bus.load_err}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk_sys);
    #1;

    // Basic word, exact latency.
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("t1_busy_rise", {31'd0, bus.load_busy}, 32'd1);
    @(posedge clk_sys);
    #1;
    send(27'h0, 16'hBEEF, 4'b0001, 16'h0000, 1'b1);
    @(negedge clk_sys);
    check("t1_lo_byte", {4'd0, bus.rom_we, bus.rom_addr, bus.rom_data}, {4'd0, 4'b0001, 16'h0000, 8'hEF});
    @(posedge clk_sys);
    #1;
    @(negedge clk_sys);
    check("t1_hi_byte", {4'd0, bus.rom_we, bus.rom_addr, bus.rom_data}, {4'd0, 4'b0001, 16'h0001, 8'hBE});
    @(posedge clk_sys);
    #1;
    end_load("t1", 1'b0);

    // Region decode; download falls with the last word still pending.
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys);
    #1;
    send(27'h08002, 16'h1122, 4'b0010, 16'h0002, 1'b1);
    send(27'h10004, 16'h3344, 4'b0100, 16'h0004, 1'b1);
    send(27'h1FFFE, 16'h5566, 4'b1000, 16'h7FFE, 1'b1);
    end_load("t2", 1'b0);

    // Out-of-range word after a valid one.
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys);
    #1;
    send(27'h00010, 16'h1234, 4'b0001, 16'h0010, 1'b1);
    send(27'h20000, 16'h5555, 4'b0000, 16'h0000, 1'b1);
    end_load("t3", 1'b1);

    // Stalled sink while three words stream; err clears on the new load.
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("t4_err_cleared", {31'd0, bus.load_err}, 32'd0);
    @(posedge clk_sys);
    #1;
    bus.rom_ready = 1'b0;
    send(27'h100, 16'hA1A0, 4'b0001, 16'h0100, 1'b1);
    @(negedge clk_sys);
    check("t4_wait_rise", {31'd0, bus.ioctl_wait}, 32'd1);
    send(27'h102, 16'hB1B0, 4'b0001, 16'h0102, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_sys);
      check("t4_stall_hold", {3'd0, bus.load_err, bus.rom_we, bus.rom_addr, bus.rom_data},
            {3'd0, 1'b0, 4'b0001, 16'h0100, 8'hA0});
    end
    @(posedge clk_sys);
    #1;
    bus.rom_ready = 1'b1;
    send(27'h104, 16'hC1C0, 4'b0001, 16'h0104, 1'b1);
    end_load("t4", 1'b0);

    // Foreign index is ignored entirely.
    bus.ioctl_index    = 8'd254;
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys);
    #1;
    send(27'h0, 16'h7777, 4'b0000, 16'h0000, 1'b0);
    repeat (3) @(negedge clk_sys);
    check("t5_ignored", {25'd0, bus.load_busy, bus.ioctl_wait, bus.load_err, bus.rom_we}, 32'd0);
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    @(posedge clk_sys);
    #1;

    // Reset with the high byte pending, then a clean reload.
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys);
    #1;
    send(27'h40, 16'h9988, 4'b0001, 16'h0040, 1'b1);
    @(posedge clk_sys);
    #1;
    bus.rom_ready = 1'b0;
    reset_n       = 1'b0;
    #1;
    check("t6_async_reset", {bus.ioctl_wait, bus.rom_we, bus.rom_addr, bus.rom_data,
                             bus.load_busy, bus.load_done, bus.load_err}, 32'd0);
    @(posedge clk_sys);
    #1;
    reset_n       = 1'b1;
    bus.rom_ready = 1'b1;
    @(posedge clk_sys);
    #1;
    send(27'h0, 16'h4321, 4'b0001, 16'h0000, 1'b1);
    end_load("t6", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
